// File: rtl/mp_addsub_seq.sv
// Byte-serial multi-precision add/subtract sequencer driving an external 8-bit adder/subtractor.
// Optional Z/N flag generation is compiled in with `define MP_ADDSUB_SEQ_FLAGS_EN.
module mp_addsub_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op_add,
    input  logic        op_bop,
    input  logic        c_in,
    input  logic [1:0]  len,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [7:0]  as_a,
    output logic [7:0]  as_b,
    output logic        as_ci,
    output logic        as_add,
    output logic        as_bop,
    input  logic [7:0]  as_y,
    input  logic        as_co,
    input  logic        as_ovf,
    output logic [31:0] result,
    output logic        c_out,
    output logic        v_out,
    output logic        z_out,
    output logic        n_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, b_q;
    logic        op_add_q, op_bop_q, c_in_q;
    logic [1:0]  len_q, cnt_q;
    logic        carry_q;
    logic [31:0] result_q, result_next;
    logic        c_q, v_q;
    logic        last_byte;

    assign last_byte = (cnt_q == len_q);

    // RESULT with the byte currently being processed replaced by the adder output.
    always_comb begin
        result_next = result_q;
        result_next[{cnt_q, 3'b000} +: 8] = as_y;
    end

    // NOTE: every variable written in always_comb gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = STEP;
            STEP:    if (last_byte) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update
    // together from values sampled before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_add_q <= 1'b0;
            op_bop_q <= 1'b0;
            c_in_q   <= 1'b0;
            len_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q      <= a_in;
                        b_q      <= b_in;
                        op_add_q <= op_add;
                        op_bop_q <= op_bop;
                        c_in_q   <= c_in;
                        len_q    <= len;
                        cnt_q    <= '0;
                        result_q <= '0;
                    end
                end
                STEP: begin
                    result_q <= result_next;
                    carry_q  <= as_co;
                    cnt_q    <= cnt_q + 2'd1;
                    if (last_byte) begin
                        c_q <= as_co;
                        v_q <= as_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    // Byte 0 takes the caller's carry; later bytes chain the previous byte's carry-out.
    always_comb begin
        as_a  = 8'h00;
        as_b  = 8'h00;
        as_ci = 1'b0;
        if (state_q == STEP) begin
            as_a  = a_q[{cnt_q, 3'b000} +: 8];
            as_b  = b_q[{cnt_q, 3'b000} +: 8];
            as_ci = (cnt_q == 2'd0) ? c_in_q : carry_q;
        end
    end

    assign as_add = op_add_q;
    assign as_bop = op_bop_q;
    assign result = result_q;
    assign c_out  = c_q;
    assign v_out  = v_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == FIN);

`ifdef MP_ADDSUB_SEQ_FLAGS_EN
    logic z_q, n_q;

    // Bytes above the current one are still zero from the clear at START.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_q <= 1'b0;
            n_q <= 1'b0;
        end else if (state_q == STEP && last_byte) begin
            z_q <= (result_next == 32'h0);
            n_q <= as_y[7];
        end
    end

    assign z_out = z_q;
    assign n_out = n_q;
`else
    assign z_out = 1'b0;
    assign n_out = 1'b0;
`endif

endmodule

// File: doc/mp_addsub_seq.md
MP_ADDSUB_SEQ -- requirements
Module: mp_addsub_seq

Interface
REQ-001 SHALL have port CLK, input, 1 bit: sole clock; all state changes on rising edge.
REQ-002 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port START, input, 1 bit: request one operation; sampled only in IDLE.
REQ-004 SHALL have port OP_ADD, input, 1 bit: 1 = add, 0 = subtract; latched on START.
REQ-005 SHALL have port OP_BOP, input, 1 bit: 1 = use B, 0 = B forced to zero (inc/dec); latched on START.
REQ-006 SHALL have port C_IN, input, 1 bit: initial carry/nBorrow for byte 0; latched on START.
REQ-007 SHALL have port LEN, input, 2 bits: operand length in bytes minus one (1..4 bytes); latched on START.
REQ-008 SHALL have ports A_IN and B_IN, inputs, 32 bits each: operands, LS byte first; latched on START.
REQ-009 SHALL have ports AS_A and AS_B, outputs, 8 bits each: current byte to the adder/subtractor stage.
REQ-010 SHALL have ports AS_CI, AS_ADD and AS_BOP, outputs, 1 bit each: carry, mode and B-enable to the adder/subtractor.
REQ-011 SHALL have ports AS_Y (input, 8 bits), AS_CO (input, 1 bit) and AS_OVF (input, 1 bit): combinational results returned by the adder/subtractor.
REQ-012 SHALL have port RESULT, output, 32 bits: assembled result.
REQ-013 SHALL have ports C_OUT, V_OUT, Z_OUT and N_OUT, outputs, 1 bit each: carry/nBorrow, overflow, zero and negative flags.
REQ-014 SHALL have ports BUSY and DONE, outputs, 1 bit each: operation in progress; one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, STEP and FIN; transitions: IDLE->STEP on START; STEP->FIN after byte LEN; FIN->IDLE unconditionally.
REQ-016 SHALL, in IDLE with START=1, latch all operands and controls, clear RESULT, clear byte counter to 0 and enter STEP.
REQ-017 SHALL, in STEP, drive AS_A/AS_B with latched byte [counter], and AS_ADD/AS_BOP with the latched OP_ADD/OP_BOP.
REQ-018 SHALL drive AS_CI from latched C_IN for byte 0 and from AS_CO registered in the previous STEP cycle for later bytes.
REQ-019 SHALL, at the end of each STEP cycle, write AS_Y into RESULT byte [counter], register AS_CO and AS_OVF, and increment the counter.
REQ-020 SHALL leave RESULT bytes above LEN at zero.
REQ-021 SHALL set C_OUT and V_OUT from AS_CO and AS_OVF of the final byte only.
REQ-022 SHALL set Z_OUT=1 iff RESULT bytes 0..LEN are all zero, and N_OUT to bit 7 of byte LEN.
REQ-023 SHALL assert BUSY in STEP and FIN, and pulse DONE high for exactly the FIN cycle; START-to-DONE latency is LEN+2 cycles.
REQ-024 SHALL hold RESULT and all flags stable from FIN until the next accepted START.
REQ-025 SHALL ignore START while BUSY=1; START in FIN SHALL be ignored, so back-to-back requests are accepted no earlier than the cycle after DONE.
REQ-026 SHALL drive AS_A, AS_B and AS_CI to 0 while not in STEP.

Reset
REQ-027 SHALL, on RST=1 at a clock edge, enter IDLE regardless of state, aborting any operation in progress.
REQ-028 SHALL reset RESULT=0, C_OUT=V_OUT=Z_OUT=N_OUT=0, BUSY=0, DONE=0, counter=0 and all latched operands to 0.
REQ-029 SHALL give RST priority over START in the same cycle.

Configuration
REQ-030 SHALL compile Z_OUT/N_OUT generation only when macro MP_ADDSUB_SEQ_FLAGS_EN is defined; without it, Z_OUT and N_OUT SHALL be constant 0 and their logic absent, with all other behaviour unchanged.

Verification
REQ-031 SHALL cover: A=0x000000FF, B=0x00000001, LEN=1, OP_ADD=1, OP_BOP=1, C_IN=0 -> RESULT=0x00000100, C=0, V=0, Z=0, DONE exactly 3 cycles after START.
REQ-032 SHALL cover: A=0x00000000, B=0x00000001, LEN=3, OP_ADD=0, OP_BOP=1, C_IN=1 -> RESULT=0xFFFFFFFF, C=0 (borrow), N=1, V=0.
REQ-033 SHALL cover: A=0x7F, B=0x01, LEN=0, add, C_IN=0 -> RESULT=0x00000080, V=1, N=1, DONE 2 cycles after START.
REQ-034 SHALL cover: A=0x0000FFFF, LEN=1, OP_ADD=1, OP_BOP=0, C_IN=1 (increment) -> RESULT=0x00000000, C=1, Z=1.
REQ-035 SHALL cover: RST asserted during the second STEP cycle of a LEN=3 operation -> next cycle IDLE, BUSY=0, RESULT=0, no DONE pulse.
REQ-036 SHALL cover: START held high continuously -> new operation accepted only in the cycle after each DONE pulse, and RESULT is never corrupted mid-operation.
